hex_rate_counter: RTL and testbench

Rate-divided 4-bit hex counter that produces the nibble driven into the board's hex-digit segment decoder. It divides the 50 MHz board clock to a selectable step rate, counts up or down, supports parallel load, and flags each step and each wrap. Its `q` output connects directly to the decoder's 4-bit data input.

---
 rtl/hex_rate_counter.sv | 87 ++++++++
 tb/tb_hex_rate_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hex_rate_counter.sv
// hex_rate_counter: rate-divided 4-bit up/down hex counter with parallel load.
// Drives the nibble for the hex-digit segment decoder and flags each step
// (tick) and each wrap (carry), both registered and aligned with the new q.
module hex_rate_counter #(
   parameter int TICKS_1HZ = 50_000_000,
   parameter int CW        = $clog2(4*TICKS_1HZ)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   input  logic          load,
   input  logic          up,
   input  logic [1:0]    rate_sel,
   input  logic [3:0]    d,
   output logic [3:0]    q,
   output logic          tick,
   output logic          carry
);

   // Terminal divider value (period minus one) for each rate_sel code:
   // 1, T, 2T, 4T cycles per step.
   logic [CW-1:0] period_m1 [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_period
         if (gi == 0) begin : g_every_cycle
            assign period_m1[gi] = '0;
         end else begin : g_divided
            assign period_m1[gi] = CW'((TICKS_1HZ << (gi - 1)) - 1);
         end
      end
   endgenerate

   logic [CW-1:0] cnt_reg, cnt_next;
   logic [3:0]    q_reg, q_next;
   logic          tick_reg, tick_next;
   logic          carry_reg, carry_next;
   logic          terminal;
   logic          wraps;

   // The >= comparison forces a step if a shorter period is selected while
   // the divider already sits beyond the new terminal value.
   assign terminal = (cnt_reg >= period_m1[rate_sel]);
   assign wraps    = up ? (q_reg == 4'hF) : (q_reg == 4'h0);

   // Next-state rules in priority order: load, hold, step, count.
   always_comb begin
      cnt_next   = cnt_reg;
      q_next     = q_reg;
      tick_next  = 1'b0;
      carry_next = 1'b0;
      if (load) begin
         q_next   = d;
         cnt_next = '0;
      end else if (!enable) begin
         cnt_next = cnt_reg;
      end else if (terminal) begin
         cnt_next   = '0;
         q_next     = up ? (q_reg + 4'd1) : (q_reg - 4'd1);
         tick_next  = 1'b1;
         carry_next = wraps;
      end else begin
         cnt_next = cnt_reg + CW'(1);
      end
   end

   // State register; reset discards any partial divider count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_reg   <= '0;
         q_reg     <= 4'h0;
         tick_reg  <= 1'b0;
         carry_reg <= 1'b0;
      end else begin
         cnt_reg   <= cnt_next;
         q_reg     <= q_next;
         tick_reg  <= tick_next;
         carry_reg <= carry_next;
      end
   end

   assign q     = q_reg;
   assign tick  = tick_reg;
   assign carry = carry_reg;

endmodule

// File: tb/tb_hex_rate_counter.sv
// Self-checking bench for hex_rate_counter with TICKS_1HZ=4: directed
// scenarios plus randomized traffic, all compared to a behavioural model.
module tb_hex_rate_counter;

   localparam int T = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       load = 1'b0;
   logic       up = 1'b1;
   logic [1:0] rate_sel = 2'b00;
   logic [3:0] d = 4'h0;
   logic [3:0] q;
   logic       tick;
   logic       carry;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state
   int m_q = 0;
   int m_div = 0;
   int m_tick = 0;
   int m_carry = 0;

   hex_rate_counter #(.TICKS_1HZ(T)) dut (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .load     (load),
      .up       (up),
      .rate_sel (rate_sel),
      .d        (d),
      .q        (q),
      .tick     (tick),
      .carry    (carry)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   function automatic int period(input int rs);
      case (rs)
         0:       return 1;
         1:       return T;
         2:       return 2*T;
         default: return 4*T;
      endcase
   endfunction

   // Model of one rising edge, applying the step rules with plain integers.
   task automatic model_edge();
      if (load) begin
         m_q = int'(d); m_div = 0; m_tick = 0; m_carry = 0;
      end else if (!enable) begin
         m_tick = 0; m_carry = 0;
      end else if (m_div >= period(int'(rate_sel)) - 1) begin
         m_carry = (up && m_q == 15) || (!up && m_q == 0) ? 1 : 0;
         m_q     = up ? (m_q + 1) % 16 : (m_q + 15) % 16;
         m_div   = 0;
         m_tick  = 1;
      end else begin
         m_div++;
         m_tick = 0; m_carry = 0;
      end
   endtask

   // Apply inputs, take one edge, compare outputs #1 later.
   task automatic cycle(input logic l, input logic e, input logic u,
                        input logic [1:0] rs, input logic [3:0] dv,
                        input string tag);
      load = l; enable = e; up = u; rate_sel = rs; d = dv;
      @(posedge clock);
      model_edge();
      #1;
      check({tag, ".q"},     int'(q),     m_q);
      check({tag, ".tick"},  int'(tick),  m_tick);
      check({tag, ".carry"}, int'(carry), m_carry);
      $display("txn %s: load=%0b en=%0b up=%0b rs=%0d d=%h -> q=%h tick=%0b carry=%0b",
               tag, l, e, u, rs, dv, q, tick, carry);
   endtask

   // Asynchronous reset pulse between edges; outputs must clear at once.
   task automatic pulse_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      m_q = 0; m_div = 0; m_tick = 0; m_carry = 0;
      check({tag, ".rst_q"},     int'(q),     0);
      check({tag, ".rst_tick"},  int'(tick),  0);
      check({tag, ".rst_carry"}, int'(carry), 0);
      #1 reset = 1'b0;
   endtask

   // Run enabled edges until tick rises; returns edge count (or -1).
   task automatic edges_to_tick(input logic u, input logic [1:0] rs,
                                input string tag, output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         cycle(1'b0, 1'b1, u, rs, 4'h0, tag);
         if (tick) begin n = i; break; end
      end
   endtask

   initial begin
      int n;
      int carries;
      int ticks;

      // Power-on reset
      reset = 1'b1;
      #3;
      check("por.q", int'(q), 0);
      check("por.tick", int'(tick), 0);
      reset = 1'b0;
      @(negedge clock);

      // Reset mid-operation: q=7, cnt=2, then reset between edges
      cycle(1'b1, 1'b0, 1'b1, 2'b01, 4'h7, "ld7");
      cycle(1'b0, 1'b1, 1'b1, 2'b01, 4'h0, "cnt1");
      cycle(1'b0, 1'b1, 1'b1, 2'b01, 4'h0, "cnt2");
      pulse_reset("midrst");
      edges_to_tick(1'b1, 2'b01, "after_rst", n);
      check("after_rst.first_step_edge", n, 4);
      check("after_rst.q_is_1", int'(q), 1);
      edges_to_tick(1'b1, 2'b01, "r01", n);
      check("r01.second_step_spacing", n, 4);
      check("r01.q_is_2", int'(q), 2);

      // rate 00 count-up through wrap from 0
      cycle(1'b1, 1'b0, 1'b1, 2'b00, 4'h0, "ld0");
      carries = 0; ticks = 0;
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 2'b00, 4'h0, "up00");
         carries += int'(carry);
         ticks   += int'(tick);
         if (carry) check("up00.carry_at_q0", int'(q), 0);
      end
      check("up00.carry_count", carries, 1);
      check("up00.tick_count", ticks, 16);

      // rate 11 with a 5-cycle enable gap mid-period
      cycle(1'b1, 1'b0, 1'b1, 2'b11, 4'h3, "ld3");
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 2'b11, 4'h0, "r11a");
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 2'b11, 4'h0, "r11gap");
      edges_to_tick(1'b1, 2'b11, "r11b", n);
      check("r11.enabled_edges_to_step", 8 + n, 16);
      check("r11.q_is_4", int'(q), 4);

      // Load A while disabled, then count down at rate 00
      cycle(1'b1, 1'b0, 1'b1, 2'b00, 4'hA, "ldA");
      check("ldA.q", int'(q), 10);
      carries = 0;
      for (int i = 0; i < 11; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, "dn00");
         carries += int'(carry);
         if (carry) check("dn00.carry_at_F", int'(q), 15);
      end
      check("dn00.carry_count", carries, 1);

      // cnt=10 at rate 11, switch to 01: immediate step then 4-cycle spacing
      cycle(1'b1, 1'b0, 1'b1, 2'b11, 4'h0, "ld0b");
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 2'b11, 4'h0, "r11c");
      edges_to_tick(1'b1, 2'b01, "switch01", n);
      check("switch01.immediate_step", n, 1);
      edges_to_tick(1'b1, 2'b01, "switch01b", n);
      check("switch01.spacing", n, 4);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         logic       l, e, u;
         logic [1:0] rs;
         logic [3:0] dv;
         l  = ($urandom_range(0, 15) == 0);
         e  = ($urandom_range(0, 3) != 0);
         u  = $urandom_range(0, 1) != 0;
         rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : rate_sel;
         dv = 4'($urandom_range(0, 15));
         cycle(l, e, u, rs, dv, "rnd");
         if ($urandom_range(0, 199) == 0) pulse_reset("rndrst");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
